// File: rtl/drv_reg_pkg.sv
// rtl/drv_reg_pkg.sv - shared FSM state, stride default and register map for drv_reg_master
package drv_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_STB,
    RD_WAIT,
    RSP
  } state_t;

  localparam int DEFAULT_ADDR_STRIDE = 4;

  localparam logic [31:0] ADDR_FIFO   = 32'h0000_0000;
  localparam logic [31:0] CNTRL       = 32'h0000_0004;
  localparam logic [31:0] STATUS      = 32'h0000_0100;
  localparam logic [31:0] TRACE_ADDR  = 32'h0000_0200;
  localparam logic [31:0] TRACE_DATA0 = 32'h0000_0210;

endpackage

// File: rtl/drv_reg_master.sv
// rtl/drv_reg_master.sv - command-driven register-bus master, single writes and read bursts
// Optional burst support: define DRV_REG_MASTER_BURST_EN to honour cmd_len/cmd_incr.
module drv_reg_master
  import drv_reg_pkg::*;
#(
  parameter int RD_LATENCY  = 1,
  parameter int ADDR_STRIDE = DEFAULT_ADDR_STRIDE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic        cmd_incr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic [31:0] master_addr,
  output logic        master_rd,
  output logic        master_wr,
  output logic [31:0] master_wdata,
  input  logic [31:0] master_rdata,
  output logic        busy
);

  localparam logic [1:0] LAST_WAIT = 2'(RD_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  wait_cnt;
  logic        accept;
  logic        rsp_accept;
  logic        capture;
  logic        more_beats;
  logic [31:0] addr_step;

  assign accept     = cmd_valid & cmd_ready;
  assign rsp_accept = rsp_valid & rsp_ready;
  assign capture    = (state == RD_WAIT) && (wait_cnt == LAST_WAIT);
  assign busy       = (state != IDLE);
  assign rsp_last   = rsp_valid & ~more_beats;

`ifdef DRV_REG_MASTER_BURST_EN
  logic [7:0] beats_left;
  logic       rd_incr;

  assign more_beats = (beats_left != 8'd0);
  assign addr_step  = rd_incr ? 32'(ADDR_STRIDE) : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      beats_left <= 8'd0;
      rd_incr    <= 1'b0;
    end else if (accept && !cmd_wr) begin
      beats_left <= cmd_len;
      rd_incr    <= cmd_incr;
    end else if (rsp_accept && more_beats) begin
      beats_left <= beats_left - 8'd1;
    end
  end
`else
  logic unused_burst_fields;

  assign unused_burst_fields = ^{cmd_len, cmd_incr};
  assign more_beats          = 1'b0;
  assign addr_step           = 32'(ADDR_STRIDE);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= 2'd0;
      master_addr  <= 32'd0;
      master_wdata <= 32'd0;
      rsp_data     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        master_addr <= cmd_addr;
        if (cmd_wr) master_wdata <= cmd_wdata;
      end
      if (state == RD_STB) wait_cnt <= 2'd0;
      else if (state == RD_WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (capture) rsp_data <= master_rdata;
      // master_addr doubles as the beat address, so it wraps naturally at 2^32
      if (rsp_accept && more_beats) master_addr <= master_addr + addr_step;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    master_wr = 1'b0;
    master_rd = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_wr ? WR : RD_STB;
      end
      WR: begin
        master_wr = 1'b1;
        state_nxt = IDLE;
      end
      RD_STB: begin
        master_rd = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_cnt == LAST_WAIT) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = more_beats ? RD_STB : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_drv_reg_master.sv
// tb/tb_drv_reg_master.sv - directed self-checking bench for drv_reg_master
module tb_drv_reg_master;
  import drv_reg_pkg::*;

`ifdef DRV_REG_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic        cmd_incr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [7:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic [31:0] master_addr;
  logic        master_rd;
  logic        master_wr;
  logic [31:0] master_wdata;
  logic [31:0] master_rdata = 32'hDEAD_BEEF;
  logic        busy;

  always #5 clk = ~clk;

  drv_reg_master #(.RD_LATENCY(1), .ADDR_STRIDE(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_incr(cmd_incr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .master_addr(master_addr), .master_rd(master_rd), .master_wr(master_wr),
    .master_wdata(master_wdata), .master_rdata(master_rdata), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int exp_wr = 0;
  int wr_hi = 0;
  int both_hi = 0;
  logic [31:0] strobe_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == STATUS) ? 32'h0000_0001 : (a ^ 32'hC3A5_5A3C);
  endfunction

  // one-cycle-latency responder; junk outside the valid cycle exposes mistimed capture
  always @(posedge clk)
    master_rdata <= master_rd ? rd_model(master_addr) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (master_rd) strobe_q.push_back(master_addr);
    if (master_wr) wr_hi++;
    if (master_rd && master_wr) both_hi++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp;
    for (int i = 0; i < 16 && rsp_valid !== 1'b1; i++) tick;
  endtask

  task automatic send_cmd(input logic wr, input logic incr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [7:0] len);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_incr = incr;
    cmd_addr = addr; cmd_wdata = wdata; cmd_len = len;
    for (int i = 0; i < 16 && cmd_ready !== 1'b1; i++) tick;
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    exp_wr++;
    send_cmd(1'b1, 1'b0, addr, data, 8'd0);
    check("wr_strobe", 32'(master_wr), 32'd1);
    check("wr_addr", master_addr, addr);
    check("wr_data", master_wdata, data);
    check("wr_no_rd", 32'(master_rd), 32'd0);
    tick;
    check("wr_single", 32'(master_wr), 32'd0);
    check("wr_addr_hold", master_addr, addr);
    check("wr_data_hold", master_wdata, data);
    check("wr_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("wr_no_rsp", 32'(rsp_valid), 32'd0);
      tick;
    end
  endtask

  task automatic run_read(input logic [31:0] addr, input logic incr, input logic [7:0] len,
                          input int stall);
    int n;
    int st;
    logic [31:0] ea;
    n = BURST ? int'(len) + 1 : 1;
    st = (stall >= n) ? n - 1 : stall;
    strobe_q.delete();
    send_cmd(1'b0, incr, addr, 32'd0, len);
    for (int b = 0; b < n; b++) begin
      ea = addr + ((BURST && incr) ? 32'(4 * b) : 32'd0);
      wait_rsp;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data", rsp_data, rd_model(ea));
      check("rsp_last", 32'(rsp_last), 32'(b == n - 1));
      if (b == st) begin
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = CNTRL; cmd_wdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
          tick;
          check("stall_valid", 32'(rsp_valid), 32'd1);
          check("stall_data", rsp_data, rd_model(ea));
        end
        check("stall_strobes", 32'(strobe_q.size()), 32'(b + 1));
        check("busy_cmd_ignored", 32'(wr_hi), 32'(exp_wr));
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      tick;
      if (b < n - 1) begin
        check("next_strobe", 32'(master_rd), 32'd1);
        check("next_addr", master_addr, ea + (incr ? 32'd4 : 32'd0));
      end
    end
    check("rd_idle", 32'(busy), 32'd0);
    check("rd_cmd_ready", 32'(cmd_ready), 32'd1);
    check("strobe_count", 32'(strobe_q.size()), 32'(n));
    for (int i = 0; i < strobe_q.size() && i < n; i++)
      check("strobe_addr", strobe_q[i], addr + ((BURST && incr) ? 32'(4 * i) : 32'd0));
  endtask

  task automatic reset_mid_burst;
    int n;
    int k;
    int exp_strobes;
    n = BURST ? 8 : 1;
    k = (n < 3) ? n : 3;
    exp_strobes = k + ((k < n) ? 1 : 0);
    strobe_q.delete();
    send_cmd(1'b0, 1'b1, TRACE_DATA0, 32'd0, 8'd7);
    for (int b = 0; b < k; b++) begin
      wait_rsp;
      check("rst_pre_data", rsp_data, rd_model(TRACE_DATA0 + 32'(4 * b)));
      tick;
    end
    reset = 1'b0;
    tick;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_last", 32'(rsp_last), 32'd0);
    check("rst_master_rd", 32'(master_rd), 32'd0);
    check("rst_master_wr", 32'(master_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_master_addr", master_addr, 32'd0);
    check("rst_master_wdata", master_wdata, 32'd0);
    tick;
    reset = 1'b1;
    tick;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) tick;
    check("rst_no_strobes", 32'(strobe_q.size()), 32'(exp_strobes));
    check("rst_still_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_incr = 1'b0;
    cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_len = 8'd0; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick;
    reset = 1'b1;
    tick;
    check("init_cmd_ready", 32'(cmd_ready), 32'd1);
    check("init_busy", 32'(busy), 32'd0);
    check("init_rsp_valid", 32'(rsp_valid), 32'd0);
    check("init_rsp_last", 32'(rsp_last), 32'd0);
    check("init_master_rd", 32'(master_rd), 32'd0);
    check("init_master_wr", 32'(master_wr), 32'd0);
    check("init_rsp_data", rsp_data, 32'd0);
    check("init_master_addr", master_addr, 32'd0);
    check("init_master_wdata", master_wdata, 32'd0);

    do_write(CNTRL, 32'h0000_0001);
    run_read(STATUS, 1'b1, 8'd0, -1);
    run_read(TRACE_DATA0, 1'b1, 8'd7, -1);
    run_read(TRACE_DATA0, 1'b1, 8'd7, 3);
    run_read(32'hFFFF_FFFC, 1'b1, 8'd1, -1);
    run_read(ADDR_FIFO, 1'b0, 8'd3, -1);
    do_write(TRACE_ADDR, 32'h1234_5678);
    reset_mid_burst;

    check("wr_strobe_total", 32'(wr_hi), 32'(exp_wr));
    check("rd_wr_exclusive", 32'(both_hi), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
